// File: rtl/led_pkg.sv
// Shared constants for the cylon display chain, so that the pattern generator
// and the LED stage agree on channel count, PWM width and decay step.
//   NLED    : number of LED channels
//   PWMBITS : width of the PWM counter and of each per-LED level
//   DSTEP   : amount a fading level loses on each decay tick
package led_pkg;

  localparam int NLED    = 12;
  localparam int PWMBITS = 8;
  localparam int DSTEP   = 16;

  // A 4-bit brightness nibble is repeated into both halves of the level, so
  // that 0x0 maps to 0x00 and 0xF maps to full scale 0xFF.
  function automatic logic [7:0] expand_bright(input logic [3:0] b);
    return {b, b};
  endfunction

endpackage

// File: rtl/led_fade_cell.sv
// One LED channel: holds the brightness level, applies the light / clamp /
// decay priority update, and registers the PWM comparison onto the LED pin.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   en           : display enable, 0 clears the level and the LED
//   pat_bit      : this channel's pattern bit, 1 = full brightness
//   max_lvl      : current full-scale level
//   dtick        : one-cycle decay tick shared by all channels
//   pwm_cnt      : shared free-running PWM phase
//   led          : registered LED drive, 1 = on
module led_fade_cell #(
  parameter int PWMBITS = led_pkg::PWMBITS,
  parameter int DSTEP   = led_pkg::DSTEP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               pat_bit,
  input  logic [PWMBITS-1:0] max_lvl,
  input  logic               dtick,
  input  logic [PWMBITS-1:0] pwm_cnt,
  output logic               led
);

  localparam logic [PWMBITS-1:0] STEP = PWMBITS'(DSTEP);

  logic [PWMBITS-1:0] level_q, level_d;
  logic               led_q, led_d;

  always_comb begin
    level_d = level_q;
    if (!en) begin
      level_d = '0;
    end else if (pat_bit) begin
      level_d = max_lvl;
    end else if (level_q > max_lvl) begin
      // Lowering the brightness pulls a fading channel down at once.
      level_d = max_lvl;
    end else if (dtick) begin
      // Saturate at zero rather than wrapping back to a bright level.
      level_d = (level_q >= STEP) ? (level_q - STEP) : '0;
    end
  end

  // Level L is on for pwm_cnt = 0..L-1, i.e. exactly L cycles per period.
  always_comb begin
    led_d = en && (pwm_cnt < level_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_afterglow_pwm.sv
// LED stage behind the cylon pattern generator. Each lit pattern bit drives
// its LED at the programmed brightness; when the bit drops the LED fades out
// linearly, leaving a trailing afterglow behind the sweeping eye.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   en           : display enable, 0 blanks and clears every channel
//   pat          : pattern bits, 1 = LED at full brightness
//   bright       : global brightness nibble, full scale = {bright,bright}
//   decay_rate   : decay prescaler advances by decay_rate+1 per clock
//   led          : registered PWM LED drive, 1 = on
//   pwm_wrap     : one-cycle pulse on the cycle after pwm_cnt was all-ones
module led_afterglow_pwm #(
  parameter int NLED    = led_pkg::NLED,
  parameter int PWMBITS = led_pkg::PWMBITS,
  parameter int MXDPRE  = 16,
  parameter int DSTEP   = led_pkg::DSTEP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic [NLED-1:0] pat,
  input  logic [3:0]      bright,
  input  logic [1:0]      decay_rate,
  output logic [NLED-1:0] led,
  output logic            pwm_wrap
);

  import led_pkg::*;

  logic [PWMBITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [MXDPRE-1:0]  dpre_q, dpre_d;
  logic               pwm_wrap_q, pwm_wrap_d;
  logic               dtick;
  logic [PWMBITS-1:0] max_lvl;

  assign max_lvl = PWMBITS'(expand_bright(bright));
  assign dtick   = (dpre_q == '1);

  // Both phases are held at zero while disabled so re-enable starts clean.
  always_comb begin
    pwm_cnt_d  = en ? (pwm_cnt_q + 1'b1) : '0;
    dpre_d     = en ? (dpre_q + MXDPRE'(decay_rate) + MXDPRE'(1)) : '0;
    pwm_wrap_d = en && (pwm_cnt_q == '1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt_q  <= '0;
      dpre_q     <= '0;
      pwm_wrap_q <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      dpre_q     <= dpre_d;
      pwm_wrap_q <= pwm_wrap_d;
    end
  end

  assign pwm_wrap = pwm_wrap_q;

  for (genvar i = 0; i < NLED; i++) begin : g_cell
    led_fade_cell #(
      .PWMBITS(PWMBITS),
      .DSTEP  (DSTEP)
    ) u_cell (
      .clock  (clock),
      .reset  (reset),
      .en     (en),
      .pat_bit(pat[i]),
      .max_lvl(max_lvl),
      .dtick  (dtick),
      .pwm_cnt(pwm_cnt_q),
      .led    (led[i])
    );
  end

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Randomized and directed stimulus for led_afterglow_pwm, checked every cycle
// against a behavioural model of the LED stage, plus literal duty-cycle,
// wrap-period and fade-out expectations.
module tb_led_afterglow_pwm;

  localparam int N    = 12;
  localparam int MXD  = 4;
  localparam int PER  = 256;
  localparam int DMOD = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] pat;
  logic [3:0]   bright;
  logic [1:0]   decay_rate;
  logic [N-1:0] led;
  logic         pwm_wrap;

  led_afterglow_pwm #(.MXDPRE(MXD)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .pat       (pat),
    .bright    (bright),
    .decay_rate(decay_rate),
    .led       (led),
    .pwm_wrap  (pwm_wrap)
  );

  always #5 clock = ~clock;

  int nchk  = 0;
  int nfail = 0;

  // Model state: PWM phase, decay phase, per-channel brightness, outputs.
  int           m_phase;
  int           m_decay;
  int           m_lvl [N];
  logic [N-1:0] m_led;
  logic         m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_decay = 0;
    for (int i = 0; i < N; i++) m_lvl[i] = 0;
    m_led  = '0;
    m_wrap = 1'b0;
  endfunction

  function automatic void model_step();
    int  full;
    bit  tick;
    full = int'(bright) * 17;
    tick = (m_decay == DMOD - 1);
    for (int i = 0; i < N; i++) m_led[i] = en && (m_phase < m_lvl[i]);
    m_wrap = en && (m_phase == PER - 1);
    for (int i = 0; i < N; i++) begin
      if (!en)                m_lvl[i] = 0;
      else if (pat[i])        m_lvl[i] = full;
      else if (m_lvl[i] > full) m_lvl[i] = full;
      else if (tick)          m_lvl[i] = (m_lvl[i] >= 16) ? m_lvl[i] - 16 : 0;
    end
    m_phase = en ? (m_phase + 1) % PER : 0;
    m_decay = en ? (m_decay + int'(decay_rate) + 1) % DMOD : 0;
  endfunction

  task automatic compare();
    chk("led", int'(led), int'(m_led));
    chk("pwm_wrap", int'(pwm_wrap), int'(m_wrap));
  endtask

  task automatic cyc();
    @(posedge clock);
    if (reset) model_reset();
    else       model_step();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic window(input int idx, output int on, output int wraps, output logic [N-1:0] others);
    on = 0; wraps = 0; others = '0;
    for (int k = 0; k < PER; k++) begin
      cyc();
      on    += int'(led[idx]);
      wraps += int'(pwm_wrap);
      for (int j = 0; j < N; j++) if (j != idx) others[j] = others[j] | led[j];
    end
  endtask

  task automatic rand_inputs();
    en = ($urandom_range(0, 29) != 0);
    if ($urandom_range(0, 3) == 0) pat = N'($urandom) & N'($urandom) & N'($urandom);
    else                           pat = '0;
    if ($urandom_range(0, 15) == 0) bright = 4'($urandom);
    if ($urandom_range(0, 31) == 0) decay_rate = 2'($urandom);
  endtask

  int           on, wraps, cnt, pos, dir;
  logic [N-1:0] oth;

  initial begin
    reset = 1'b1; en = 1'b0; pat = '0; bright = 4'd0; decay_rate = 2'd0;
    model_reset();
    #2;
    chk("reset_led", int'(led), 0);
    chk("reset_wrap", int'(pwm_wrap), 0);
    run(3);
    #2 reset = 1'b0;

    // Random warm-up.
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      cyc();
    end

    // Asynchronous reset in the middle of a lit display.
    en = 1'b1; pat = 12'hFFF; bright = 4'hF;
    run(20);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_led", int'(led), 0);
    chk("async_reset_wrap", int'(pwm_wrap), 0);
    en = 1'b0;
    #2 reset = 1'b0;
    run(20);
    chk("blank_after_reset", int'(led), 0);

    // Full brightness on LED 0.
    en = 1'b1; bright = 4'hF; pat = 12'h001; decay_rate = 2'($urandom);
    run(10);
    window(0, on, wraps, oth);
    chk("full_on_cycles", on, 255);
    chk("full_other_leds", int'(oth), 0);
    chk("full_wrap_count", wraps, 1);

    // Scaled brightness on LED 11, then lowered brightness.
    bright = 4'h4; pat = 12'h800;
    run(10);
    window(11, on, wraps, oth);
    chk("bright4_on_cycles", on, 68);
    bright = 4'h1;
    run(2);
    window(11, on, wraps, oth);
    chk("bright1_on_cycles", on, 17);

    // Clamp of a fading level when brightness is lowered.
    bright = 4'hF; pat = 12'h004; run(5);
    pat = '0; bright = 4'h2; run(300);

    // Fade of LED 5 from a one-cycle pulse; must end dark, never wrap.
    en = 1'b0; cyc(); en = 1'b1;
    bright = 4'hF; decay_rate = 2'd0; pat = 12'h020;
    cyc();
    pat = '0;
    run(300);
    window(5, on, wraps, oth);
    chk("fade_end_dark", on, 0);

    // Held pattern bit wins over decay ticks.
    decay_rate = 2'd2; pat = 12'h008;
    run(10);
    window(3, on, wraps, oth);
    chk("pat_beats_dtick", on, 255);

    // Enable drop mid-fade, then PWM phase restarts from zero.
    pat = 12'hFFF; run(5);
    pat = '0; run(20);
    en = 1'b0;
    cyc();
    chk("en_drop_led", int'(led), 0);
    en = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 400; k++) begin
      cyc();
      if (pwm_wrap) begin cnt = k; break; end
    end
    chk("first_wrap_after_reenable", cnt, 256);

    // Cylon sweep: one-hot bouncing every 64 cycles.
    decay_rate = 2'd0; bright = 4'($urandom_range(1, 15)); pos = 0; dir = 1;
    for (int s = 0; s < 24; s++) begin
      pat = N'(1) << pos;
      run(64);
      if (pos == N - 1) dir = -1;
      else if (pos == 0) dir = 1;
      pos += dir;
    end

    // Random tail.
    for (int k = 0; k < 2000; k++) begin
      rand_inputs();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
